// File: rtl/uart_tx.sv
// UART transmitter (8N1, LSB first) fed by a byte FIFO; pop one cycle after a push into an idle empty FIFO, tx one cycle later.
// tx_ready = !full; frames run back to back while bytes are queued.
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count_q;
    logic [BW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            push, pop, bit_done, fifo_empty;

    assign tx_ready   = (count_q != CW'(FIFO_DEPTH));
    assign push       = tx_valid && tx_ready;
    assign fifo_empty = (count_q == '0);
    assign bit_done   = (cnt_q == BW'(CLKS_PER_BIT - 1));
    assign tx         = tx_q;
    assign tx_busy    = (state_q != IDLE) || !fifo_empty;
    assign fifo_count = count_q;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // The line level is decoded from the current state and registered,
    // so tx trails the state register by one cycle for every bit alike.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_done) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                tx_d = shift_q[idx_q];
                if (bit_done) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_done) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // Chain straight into the next start bit when more data waits.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                cnt_d   = '0;
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with a behavioural line receiver recording bytes and start-bit cycles.
module tb_uart_tx;

    localparam int C  = 16;
    localparam int FD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;
    logic [2:0] fifo_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] rx_q[$];
    int         start_q[$];
    int         framing_err = 0;
    logic       mon_act = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_sh = 8'h00;

    uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(FD)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Receiver: samples mid-bit, relative to the first low level seen on the line.
    always @(negedge clk) begin
        if (rst) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (tx === 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
                start_q.push_back(cyc);
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % C == C / 2) begin
                if (mon_cnt / C >= 1 && mon_cnt / C <= 8) begin
                    mon_sh[mon_cnt / C - 1] = tx;
                end else if (mon_cnt / C == 9) begin
                    if (tx === 1'b1) rx_q.push_back(mon_sh);
                    else framing_err++;
                    mon_act = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [7:0] d, output logic acc, output int edge_n);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        acc      = tx_ready;
        @(posedge clk);
        #1;
        edge_n   = cyc;
        tx_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_rx(input int n, input int limit);
        for (int i = 0; i < limit && rx_q.size() < n; i++) cycles(1);
    endtask

    task automatic test_reset();
        logic acc;
        int   n;
        int   low_seen;
        rst = 1'b1;
        cycles(3);
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL rst_tx: got %b expected 1", tx); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b expected 1", tx_ready); end
        checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", tx_busy); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL rst_count: got %0d expected 0", fifo_count); end
        @(negedge clk);
        rst = 1'b0;
        push(8'h81, acc, n);
        cycles(5);
        checks++; if (tx !== 1'b0) begin failures++; $display("FAIL pre_rst_tx: got %b expected 0", tx); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL async_rst_tx: got %b expected 1", tx); end
        checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL async_rst_busy: got %b expected 0", tx_busy); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL async_rst_count: got %0d expected 0", fifo_count); end
        cycles(2);
        @(negedge clk);
        rst = 1'b0;
        low_seen = 0;
        for (int i = 0; i < 100; i++) begin
            cycles(1);
            if (tx !== 1'b1) low_seen++;
        end
        checks++; if (low_seen != 0) begin failures++; $display("FAIL idle_tx: got %0d low cycles expected 0", low_seen); end
        checks++; if (rx_q.size() != 0) begin failures++; $display("FAIL idle_rx: got %0d bytes expected 0", rx_q.size()); end
    endtask

    task automatic test_single();
        logic       acc;
        int         n;
        logic [9:0] frame;
        int         err [10];
        frame = {1'b1, 8'hA5, 1'b0};
        foreach (err[i]) err[i] = 0;
        rx_q.delete();
        push(8'hA5, acc, n);
        checks++; if (acc !== 1'b1) begin failures++; $display("FAIL single_acc: got %b expected 1", acc); end
        for (int k = 1; k <= 161; k++) begin
            cycles(1);
            if (k == 1) begin
                checks++; if (tx !== 1'b1) begin failures++; $display("FAIL single_lat: got %b expected 1", tx); end
            end else begin
                if (tx !== frame[(k - 2) / C]) err[(k - 2) / C]++;
            end
            if (k == 160) begin
                checks++; if (tx_busy !== 1'b1) begin failures++; $display("FAIL single_busy_stop: got %b expected 1", tx_busy); end
            end
        end
        for (int b = 0; b < 10; b++) begin
            checks++; if (err[b] != 0) begin failures++; $display("FAIL single_bit%0d: got %0d bad cycles expected 0 (level %b)", b, err[b], frame[b]); end
        end
        checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL single_busy_end: got %b expected 0", tx_busy); end
        checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin failures++; $display("FAIL single_rx: got %0d bytes expected one 0xa5", rx_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [4] = '{8'h00, 8'hFF, 8'h55, 8'h3C};
        logic       acc;
        int         n;
        rx_q.delete();
        start_q.delete();
        for (int i = 0; i < 4; i++) begin
            push(exp[i], acc, n);
            checks++; if (acc !== 1'b1) begin failures++; $display("FAIL b2b_acc%0d: got %b expected 1", i, acc); end
        end
        wait_rx(4, 800);
        cycles(20);
        checks++; if (rx_q.size() != 4) begin failures++; $display("FAIL b2b_count: got %0d expected 4", rx_q.size()); end
        for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp[i]) begin failures++; $display("FAIL b2b_byte%0d: got %h expected %h", i, rx_q[i], exp[i]); end
        end
        for (int i = 1; i < 4 && i < start_q.size(); i++) begin
            checks++; if (start_q[i] - start_q[i-1] != 10 * C) begin failures++; $display("FAIL b2b_gap%0d: got %0d expected %0d", i, start_q[i] - start_q[i-1], 10 * C); end
        end
        checks++; if (framing_err != 0) begin failures++; $display("FAIL b2b_framing: got %0d expected 0", framing_err); end
        checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL b2b_idle: got %b expected 0", tx_busy); end
    endtask

    task automatic test_full();
        logic [7:0] exp [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        logic       exp_acc [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       acc;
        int         n;
        rx_q.delete();
        push(exp[0], acc, n);
        cycles(3);
        for (int i = 1; i < 6; i++) begin
            push(exp[i], acc, n);
            checks++; if (acc !== exp_acc[i]) begin failures++; $display("FAIL full_acc%0d: got %b expected %b", i, acc, exp_acc[i]); end
        end
        checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL full_count: got %0d expected 4", fifo_count); end
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL full_ready: got %b expected 0", tx_ready); end
        wait_rx(5, 1000);
        cycles(200);
        checks++; if (rx_q.size() != 5) begin failures++; $display("FAIL full_rx_count: got %0d expected 5", rx_q.size()); end
        for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp[i]) begin failures++; $display("FAIL full_byte%0d: got %h expected %h", i, rx_q[i], exp[i]); end
        end
    endtask

    task automatic test_simul_push_pop();
        logic [7:0] exp [3] = '{8'hC3, 8'h3A, 8'h96};
        logic       acc;
        int         n0;
        int         n;
        rx_q.delete();
        start_q.delete();
        push(exp[0], acc, n0);
        cycles(3);
        push(exp[1], acc, n);
        checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL sim_pre_count: got %0d expected 1", fifo_count); end
        cycles(n0 + 160 - cyc);
        push(exp[2], acc, n);
        checks++; if (acc !== 1'b1) begin failures++; $display("FAIL sim_acc: got %b expected 1", acc); end
        checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL sim_count: got %0d expected 1", fifo_count); end
        wait_rx(3, 700);
        cycles(200);
        checks++; if (rx_q.size() != 3) begin failures++; $display("FAIL sim_rx_count: got %0d expected 3", rx_q.size()); end
        for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp[i]) begin failures++; $display("FAIL sim_byte%0d: got %h expected %h", i, rx_q[i], exp[i]); end
        end
        for (int i = 1; i < 3 && i < start_q.size(); i++) begin
            checks++; if (start_q[i] - start_q[i-1] != 10 * C) begin failures++; $display("FAIL sim_gap%0d: got %0d expected %0d", i, start_q[i] - start_q[i-1], 10 * C); end
        end
        checks++; if (framing_err != 0) begin failures++; $display("FAIL sim_framing: got %0d expected 0", framing_err); end
    endtask

    task automatic test_reset_mid_frame();
        logic acc;
        int   n0;
        int   n;
        int   low_seen;
        rx_q.delete();
        push(8'h0F, acc, n0);
        push(8'hA1, acc, n);
        push(8'hB2, acc, n);
        checks++; if (fifo_count !== 3'd2) begin failures++; $display("FAIL rmf_queued: got %0d expected 2", fifo_count); end
        cycles(n0 + 72 - cyc);
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL rmf_bit3: got %b expected 1", tx); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL rmf_tx: got %b expected 1", tx); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL rmf_count: got %0d expected 0", fifo_count); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL rmf_ready: got %b expected 1", tx_ready); end
        checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL rmf_busy: got %b expected 0", tx_busy); end
        cycles(2);
        @(negedge clk);
        rst = 1'b0;
        low_seen = 0;
        for (int i = 0; i < 400; i++) begin
            cycles(1);
            if (tx !== 1'b1) low_seen++;
        end
        checks++; if (low_seen != 0) begin failures++; $display("FAIL rmf_quiet: got %0d low cycles expected 0", low_seen); end
        checks++; if (rx_q.size() != 0) begin failures++; $display("FAIL rmf_rx: got %0d bytes expected 0", rx_q.size()); end
        checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL rmf_busy_after: got %b expected 0", tx_busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_simul_push_pop();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
